nrx_input_cond: RTL and testbench
=================================

# nrx_input_cond

Player-input conditioner for the New Rally-X core. Decodes PS/2 key events and merges them with the two HPS joystick words. Stretches every coin press to a fixed number of video frames, so that a short key tap or a long held button both give the CPU exactly one valid coin. Sits between hps_io/keyboard sources and the game core's CTR1/CTR2 ports; the frame reference is the VBLK output of the video timing generator.

## Interface
- COIN_FRAMES, 3: coin pulse length in VBLK rising edges; legal range 1..15.
- CLK24M  in  1  system clock (24 MHz).
- RESET_N  in  1  asynchronous active-low reset.
- PS2_KEY  in  11  [10] event toggle, [9] pressed, [8:0] extended scan code.
- JOY1, JOY2  in  16 each  joystick bits:
  - [0] right, [1] left, [2] down, [3] up;
  - [4] fire, [5] start1, [6] start2, [7] coin.
- VBLK  in  1  vertical blank level from video timing, CLK24M-synchronous.
- CABINET  in  1  0 upright, 1 cocktail; quasi-static.
- CTR1  out  8  active-low ~{coin1,start1,up1,down1,right1,left1,trig1,1'b0}.
- CTR2  out  8  active-low ~{coin2,start2,up2,down2,right2,left2,trig2,CABINET}.

## Operation
- Reset (async assert, sync release):
  - CTR1=8'hFF, CTR2=8'hFF.
  - All key-state bits 0, coin FSMs IDLE, counters 0.
  - Primed flag 0.
- Key event detection:
  - Stored toggle copy T updates every cycle.
  - First cycle after reset release: capture T and set primed; no decode.
  - After that, PS2_KEY[10]!=T is an event: update the mapped key bit to PS2_KEY[9].
  - Unmapped codes are ignored.
- Key map (code -> bit):
  - x75 up, x72 down, x6B left, x74 right (extended bit don't-care).
  - 029/014 fire.
  - 005 F1 (start1 and coin1), 006 F2 (start2 and coin2).
  - 016 start1, 01E start2, 02E coin1, 036 coin2.
  - 02D up2, 02B down2, 023 left2, 034 right2.
  - 01C/01B fire2.
- Merge:
  - P2 directions/fire = key2 OR JOY2[4:0].
  - start1 = F1|016|JOY1[5]|JOY2[5]; start2 likewise with [6].
  - P1 directions/fire = key1 OR JOY1 bit, OR the P2 value when CABINET=0.
  - raw coin1 = F1|02E|JOY1[7]; raw coin2 = F2|036|JOY2[7].
- Coin FSM, one per channel; rise = raw & ~raw_d, VBLK rise = VBLK & ~VBLK_d.
  - IDLE: on rise, go to PULSE, count=0.
  - PULSE: count increments on each VBLK rise. On the edge where count would reach COIN_FRAMES, go to WAIT_REL if raw=1, else IDLE.
  - WAIT_REL: go to IDLE when raw=0.
  - The coin bit is asserted only in PULSE.
  - Rises during PULSE/WAIT_REL are ignored: no extension, no queuing.
- Simultaneous events: a VBLK rise on the same edge as the coin rise is not counted, so the pulse spans COIN_FRAMES further VBLK rises.

## Timing
- CTR1/CTR2 are registered. Latency from input to CTR edge:
  - JOY change: 1 edge.
  - PS2 event: 2 edges (key state, then output).
  - Coin rise: 2 edges (FSM, then output).
- Coin pulse length: from the output register edge after PULSE entry until the output edge after the COIN_FRAMES-th VBLK rise.
- Reset mid-pulse: coin deasserts immediately (async). After release, a coin still held does not re-trigger until it is released and pressed again, because raw_d resets to 0 and primed gating applies to raw too: no rise is accepted in the first cycle.
- Counter saturates; it never wraps.

## Test plan
- Reset with PS2_KEY[10]=1 and all other inputs 0, release -> CTR1=CTR2=8'hFF, with no key event decoded.
- Toggle PS2_KEY[10] with {pressed=1, code=9'h175} -> CTR1[5]=0 two edges later. Toggle again with pressed=0 -> CTR1[5]=1.
- JOY2[3]=1, CABINET=0 -> CTR1[5]=0 and CTR2[5]=0 after 1 edge. Set CABINET=1 -> CTR1[5]=1, CTR2[0]=0.
- COIN_FRAMES=3, JOY1[7] held high for 10 frames -> CTR1[7]=0 until the output edge after the 3rd VBLK rise, then 1. No second pulse until release and re-press.
- Code 02E pressed for 1 cycle, with a second press during PULSE -> exactly one 3-frame pulse.
- RESET_N low during PULSE -> CTR1[7]=1 immediately. With coin held through release -> no new pulse.

Source files
------------

// File: rtl/nrx_input_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : nrx_input_cond_if
// Description : Player-input bundle for the New Rally-X input conditioner.
//               It carries the keyboard event word, the two joystick words,
//               the frame reference and cabinet strap into the conditioner,
//               and the two active-low control bytes back to the game core.
// Revision    : 1.0 - initial release
// ============================================================================
interface nrx_input_cond_if;
  logic [10:0] PS2_KEY;
  logic [15:0] JOY1;
  logic [15:0] JOY2;
  logic        VBLK;
  logic        CABINET;
  logic [7:0]  CTR1;
  logic [7:0]  CTR2;

  // Input sources (hps_io, keyboard, video timing) drive the conditioner
  modport master (
    output PS2_KEY, JOY1, JOY2, VBLK, CABINET,
    input  CTR1, CTR2
  );

  // The conditioner itself
  modport slave (
    input  PS2_KEY, JOY1, JOY2, VBLK, CABINET,
    output CTR1, CTR2
  );
endinterface
`default_nettype wire

// File: rtl/nrx_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : nrx_input_cond
// Description : Decodes PS/2 key events, merges them with two joystick
//               words and stretches each coin press into a pulse of exactly
//               COIN_FRAMES vertical-blank periods. Outputs are the
//               active-low CTR1/CTR2 bytes of the game core.
// Revision    : 1.0 - initial release
// ============================================================================
module nrx_input_cond #(
  parameter int COIN_FRAMES = 3   // pulse length in VBLK rises, 1..15
) (
  input  wire logic        CLK24M,
  input  wire logic        RESET_N,
  nrx_input_cond_if.slave  bus
);

  // Bit positions inside the keyboard state vector
  localparam int c_key_up1    = 0;
  localparam int c_key_down1  = 1;
  localparam int c_key_left1  = 2;
  localparam int c_key_right1 = 3;
  localparam int c_key_fire1  = 4;
  localparam int c_key_f1     = 5;
  localparam int c_key_f2     = 6;
  localparam int c_key_start1 = 7;
  localparam int c_key_start2 = 8;
  localparam int c_key_coin1  = 9;
  localparam int c_key_coin2  = 10;
  localparam int c_key_up2    = 11;
  localparam int c_key_down2  = 12;
  localparam int c_key_left2  = 13;
  localparam int c_key_right2 = 14;
  localparam int c_key_fire2  = 15;

  localparam logic [4:0] c_coin_frames = 5'(COIN_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } coin_state_t;

  logic        r_tog;
  logic        r_primed;
  logic [15:0] r_key;
  logic        r_vblk_d;
  logic [7:0]  r_ctr1;
  logic [7:0]  r_ctr2;

  logic [15:0] w_key_sel;
  logic        w_key_event;
  logic        w_vblk_rise;
  logic [1:0]  w_coin_raw;
  logic [1:0]  w_coin_on;

  logic w_up2, w_down2, w_left2, w_right2, w_fire2;
  logic w_up1, w_down1, w_left1, w_right1, w_fire1;
  logic w_start1, w_start2;
  logic w_share;

  // Upper joystick bits carry nothing this core uses
  logic w_unused_bits;
  assign w_unused_bits = ^{bus.JOY1[15:8], bus.JOY2[15:8]};

  // Toggle differs from the stored copy -> a new key event, once primed
  assign w_key_event = r_primed && (bus.PS2_KEY[10] != r_tog);
  assign w_vblk_rise = bus.VBLK && !r_vblk_d;

  // Scan code to key-state bit; arrows ignore the extended flag
  always_comb begin
    w_key_sel = '0;
    case (bus.PS2_KEY[7:0])
      8'h75:   w_key_sel[c_key_up1]    = 1'b1;
      8'h72:   w_key_sel[c_key_down1]  = 1'b1;
      8'h6B:   w_key_sel[c_key_left1]  = 1'b1;
      8'h74:   w_key_sel[c_key_right1] = 1'b1;
      default: ;
    endcase
    case (bus.PS2_KEY[8:0])
      9'h029, 9'h014: w_key_sel[c_key_fire1]  = 1'b1;
      9'h005:         w_key_sel[c_key_f1]     = 1'b1;
      9'h006:         w_key_sel[c_key_f2]     = 1'b1;
      9'h016:         w_key_sel[c_key_start1] = 1'b1;
      9'h01E:         w_key_sel[c_key_start2] = 1'b1;
      9'h02E:         w_key_sel[c_key_coin1]  = 1'b1;
      9'h036:         w_key_sel[c_key_coin2]  = 1'b1;
      9'h02D:         w_key_sel[c_key_up2]    = 1'b1;
      9'h02B:         w_key_sel[c_key_down2]  = 1'b1;
      9'h023:         w_key_sel[c_key_left2]  = 1'b1;
      9'h034:         w_key_sel[c_key_right2] = 1'b1;
      9'h01C, 9'h01B: w_key_sel[c_key_fire2]  = 1'b1;
      default: ;
    endcase
  end

  // Keyboard event tracking: first cycle after reset only captures the toggle
  always_ff @(posedge CLK24M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_tog    <= 1'b0;
      r_primed <= 1'b0;
      r_key    <= '0;
      r_vblk_d <= 1'b0;
    end else begin
      r_tog    <= bus.PS2_KEY[10];
      r_primed <= 1'b1;
      r_vblk_d <= bus.VBLK;
      if (w_key_event) begin
        r_key <= (r_key & ~w_key_sel) | (w_key_sel & {16{bus.PS2_KEY[9]}});
      end
    end
  end

  // Player merge; in upright cabinets player 2 controls also drive player 1
  always_comb begin
    w_share  = !bus.CABINET;
    w_up2    = r_key[c_key_up2]    | bus.JOY2[3];
    w_down2  = r_key[c_key_down2]  | bus.JOY2[2];
    w_left2  = r_key[c_key_left2]  | bus.JOY2[1];
    w_right2 = r_key[c_key_right2] | bus.JOY2[0];
    w_fire2  = r_key[c_key_fire2]  | bus.JOY2[4];
    w_start1 = r_key[c_key_f1] | r_key[c_key_start1] | bus.JOY1[5] | bus.JOY2[5];
    w_start2 = r_key[c_key_f2] | r_key[c_key_start2] | bus.JOY1[6] | bus.JOY2[6];
    w_up1    = r_key[c_key_up1]    | bus.JOY1[3] | (w_share & w_up2);
    w_down1  = r_key[c_key_down1]  | bus.JOY1[2] | (w_share & w_down2);
    w_left1  = r_key[c_key_left1]  | bus.JOY1[1] | (w_share & w_left2);
    w_right1 = r_key[c_key_right1] | bus.JOY1[0] | (w_share & w_right2);
    w_fire1  = r_key[c_key_fire1]  | bus.JOY1[4] | (w_share & w_fire2);
    w_coin_raw[0] = r_key[c_key_f1] | r_key[c_key_coin1] | bus.JOY1[7];
    w_coin_raw[1] = r_key[c_key_f2] | r_key[c_key_coin2] | bus.JOY2[7];
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_coin
    coin_state_t r_state;
    logic [3:0]  r_cnt;
    logic        r_raw_d;
    logic        r_on;
    logic        w_rise;
    logic [4:0]  w_cnt_inc;

    // A press counts only once the block is primed, so a coin held
    // through reset release never produces a rise
    assign w_rise    = r_primed && w_coin_raw[ch] && !r_raw_d;
    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
    assign w_coin_on[ch] = r_on;

    // Coin stretcher: one fixed-length pulse per press, held presses wait
    always_ff @(posedge CLK24M or negedge RESET_N) begin
      if (!RESET_N) begin
        r_state <= ST_IDLE;
        r_cnt   <= 4'd0;
        r_raw_d <= 1'b0;
        r_on    <= 1'b0;
      end else begin
        r_raw_d <= w_coin_raw[ch];
        case (r_state)
          ST_IDLE: begin
            if (w_rise) begin
              r_state <= ST_PULSE;
              r_cnt   <= 4'd0;
              r_on    <= 1'b1;
            end
          end
          ST_PULSE: begin
            if (w_vblk_rise) begin
              if (r_cnt != 4'hF) begin
                r_cnt <= w_cnt_inc[3:0];
              end
              if (w_cnt_inc >= c_coin_frames) begin
                r_state <= w_coin_raw[ch] ? ST_WAIT_REL : ST_IDLE;
                r_on    <= 1'b0;
              end
            end
          end
          ST_WAIT_REL: begin
            if (!w_coin_raw[ch]) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_on    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Registered active-low control bytes
  always_ff @(posedge CLK24M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ctr1 <= 8'hFF;
      r_ctr2 <= 8'hFF;
    end else begin
      r_ctr1 <= ~{w_coin_on[0], w_start1, w_up1, w_down1,
                  w_right1, w_left1, w_fire1, 1'b0};
      r_ctr2 <= ~{w_coin_on[1], w_start2, w_up2, w_down2,
                  w_right2, w_left2, w_fire2, bus.CABINET};
    end
  end

  assign bus.CTR1 = r_ctr1;
  assign bus.CTR2 = r_ctr2;

endmodule
`default_nettype wire

// File: tb/tb_nrx_input_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_nrx_input_cond
// Description : Self-checking bench for nrx_input_cond. Directed scenarios
//               followed by random input traffic, compared each cycle with
//               a behavioural model of the conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nrx_input_cond;

  localparam int COIN_FRAMES = 3;
  localparam int FRAME_LEN   = 16;
  localparam int VB_LEN      = 3;

  // Model key indices
  localparam int K_UP1 = 0, K_DN1 = 1, K_LT1 = 2, K_RT1 = 3, K_FR1 = 4;
  localparam int K_F1 = 5, K_F2 = 6, K_ST1 = 7, K_ST2 = 8, K_CN1 = 9, K_CN2 = 10;
  localparam int K_UP2 = 11, K_DN2 = 12, K_LT2 = 13, K_RT2 = 14, K_FR2 = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nrx_input_cond_if bus();

  nrx_input_cond #(.COIN_FRAMES(COIN_FRAMES)) dut (
    .CLK24M  (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit [15:0]  m_key;
  bit         m_tog;
  bit         m_primed;
  int         m_left [2];     // VBLK rises still to go in the current pulse
  bit         m_block [2];    // pulse finished while still held
  bit         m_raw_prev [2];
  bit         m_vb_prev;
  logic [7:0] exp1, exp2;

  int cyc    = 0;
  int pulses = 0;
  bit prev_c1 = 1'b1;

  logic [8:0] code_tbl [20] = '{9'h175, 9'h072, 9'h16B, 9'h074, 9'h029,
                                9'h014, 9'h005, 9'h006, 9'h016, 9'h01E,
                                9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023,
                                9'h034, 9'h01C, 9'h01B, 9'h0AA, 9'h112};

  function automatic int key_of(input logic [8:0] c);
    if (c[7:0] == 8'h75) return K_UP1;
    if (c[7:0] == 8'h72) return K_DN1;
    if (c[7:0] == 8'h6B) return K_LT1;
    if (c[7:0] == 8'h74) return K_RT1;
    case (c)
      9'h029, 9'h014: return K_FR1;
      9'h005: return K_F1;
      9'h006: return K_F2;
      9'h016: return K_ST1;
      9'h01E: return K_ST2;
      9'h02E: return K_CN1;
      9'h036: return K_CN2;
      9'h02D: return K_UP2;
      9'h02B: return K_DN2;
      9'h023: return K_LT2;
      9'h034: return K_RT2;
      9'h01C, 9'h01B: return K_FR2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_key      = '0;
    m_tog      = 1'b0;
    m_primed   = 1'b0;
    m_left     = '{0, 0};
    m_block    = '{1'b0, 1'b0};
    m_raw_prev = '{1'b0, 1'b0};
    m_vb_prev  = 1'b0;
    exp1       = 8'hFF;
    exp2       = 8'hFF;
  endtask

  // One clock edge of the model, using the inputs present at that edge
  task automatic model_edge();
    bit up2, dn2, lt2, rt2, fr2, st1, st2, up1, dn1, lt1, rt1, fr1, share, vrise;
    bit raw [2];
    int idx;
    if (!rst_n) begin
      model_reset();
      return;
    end
    share = !bus.CABINET;
    up2 = m_key[K_UP2] | bus.JOY2[3];
    dn2 = m_key[K_DN2] | bus.JOY2[2];
    lt2 = m_key[K_LT2] | bus.JOY2[1];
    rt2 = m_key[K_RT2] | bus.JOY2[0];
    fr2 = m_key[K_FR2] | bus.JOY2[4];
    st1 = m_key[K_F1] | m_key[K_ST1] | bus.JOY1[5] | bus.JOY2[5];
    st2 = m_key[K_F2] | m_key[K_ST2] | bus.JOY1[6] | bus.JOY2[6];
    up1 = m_key[K_UP1] | bus.JOY1[3] | (share & up2);
    dn1 = m_key[K_DN1] | bus.JOY1[2] | (share & dn2);
    lt1 = m_key[K_LT1] | bus.JOY1[1] | (share & lt2);
    rt1 = m_key[K_RT1] | bus.JOY1[0] | (share & rt2);
    fr1 = m_key[K_FR1] | bus.JOY1[4] | (share & fr2);
    exp1 = ~{(m_left[0] > 0), st1, up1, dn1, rt1, lt1, fr1, 1'b0};
    exp2 = ~{(m_left[1] > 0), st2, up2, dn2, rt2, lt2, fr2, bus.CABINET};

    raw[0] = m_key[K_F1] | m_key[K_CN1] | bus.JOY1[7];
    raw[1] = m_key[K_F2] | m_key[K_CN2] | bus.JOY2[7];
    vrise  = bus.VBLK && !m_vb_prev;
    for (int ch = 0; ch < 2; ch++) begin
      if (m_left[ch] > 0) begin
        if (vrise) begin
          m_left[ch]--;
          if (m_left[ch] == 0) m_block[ch] = raw[ch];
        end
      end else if (m_block[ch]) begin
        if (!raw[ch]) m_block[ch] = 1'b0;
      end else if (m_primed && raw[ch] && !m_raw_prev[ch]) begin
        m_left[ch] = COIN_FRAMES;
      end
      m_raw_prev[ch] = raw[ch];
    end
    m_vb_prev = bus.VBLK;

    if (m_primed && (bus.PS2_KEY[10] != m_tog)) begin
      idx = key_of(bus.PS2_KEY[8:0]);
      if (idx >= 0) m_key[idx] = bus.PS2_KEY[9];
    end
    m_tog    = bus.PS2_KEY[10];
    m_primed = 1'b1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs == expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Advance n clocks, checking both bytes against the model after each edge
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("ctr1", bus.CTR1, exp1);
      check("ctr2", bus.CTR2, exp2);
      if (rst_n && prev_c1 && !bus.CTR1[7]) pulses++;
      prev_c1  = bus.CTR1[7];
      cyc++;
      bus.VBLK = (cyc % FRAME_LEN) < VB_LEN;
    end
  endtask

  task automatic ps2_event(input bit pressed, input logic [8:0] code);
    bus.PS2_KEY = {~bus.PS2_KEY[10], pressed, code};
  endtask

  task automatic random_inputs();
    int r;
    int b;
    r = $urandom_range(0, 99);
    if (r < 12) begin
      b = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1) bus.JOY1[b] = ~bus.JOY1[b];
      else                           bus.JOY2[b] = ~bus.JOY2[b];
    end else if (r < 22) begin
      ps2_event(1'($urandom_range(0, 1)), code_tbl[$urandom_range(0, 19)]);
    end else if (r == 22) begin
      bus.CABINET = ~bus.CABINET;
    end
  endtask

  initial begin
    bus.PS2_KEY = 11'h400;
    bus.JOY1    = '0;
    bus.JOY2    = '0;
    bus.VBLK    = 1'b0;
    bus.CABINET = 1'b0;
    model_reset();

    // Reset state, toggle already high: no event may be decoded on release
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctr1", bus.CTR1, 8'hFF);
    check("rst_ctr2", bus.CTR2, 8'hFF);
    rst_n = 1'b1;
    step(3);
    check("nokey_ctr1", bus.CTR1, 8'hFF);
    check("nokey_ctr2", bus.CTR2, 8'hFF);

    // Keyboard up arrow: two-edge latency
    ps2_event(1'b1, 9'h175);
    step(1);
    check("up_key_lat1", {7'd0, bus.CTR1[5]}, 8'd1);
    step(1);
    check("up_key_press", {7'd0, bus.CTR1[5]}, 8'd0);
    ps2_event(1'b0, 9'h175);
    step(2);
    check("up_key_rel", {7'd0, bus.CTR1[5]}, 8'd1);

    // Joystick 2 up: upright shares to player 1, cocktail does not
    bus.JOY2[3] = 1'b1;
    step(1);
    check("joy2_up_p1", {7'd0, bus.CTR1[5]}, 8'd0);
    check("joy2_up_p2", {7'd0, bus.CTR2[5]}, 8'd0);
    bus.CABINET = 1'b1;
    step(1);
    check("cocktail_p1", {7'd0, bus.CTR1[5]}, 8'd1);
    check("cocktail_cab", {7'd0, bus.CTR2[0]}, 8'd0);
    bus.JOY2[3] = 1'b0;
    bus.CABINET = 1'b0;
    step(2);

    // Coin held for 10 frames gives one pulse; re-press gives one more
    pulses = 0;
    bus.JOY1[7] = 1'b1;
    step(10 * FRAME_LEN);
    bus.JOY1[7] = 1'b0;
    step(FRAME_LEN);
    check_int("hold_pulses", pulses, 1);
    bus.JOY1[7] = 1'b1;
    step(5 * FRAME_LEN);
    bus.JOY1[7] = 1'b0;
    step(2);
    check_int("repress_pulses", pulses, 2);

    // Short key tap with a second tap inside the pulse
    pulses = 0;
    ps2_event(1'b1, 9'h02E);
    step(1);
    ps2_event(1'b0, 9'h02E);
    step(FRAME_LEN);
    ps2_event(1'b1, 9'h02E);
    step(1);
    ps2_event(1'b0, 9'h02E);
    step(5 * FRAME_LEN);
    check_int("tap_pulses", pulses, 1);

    // Reset in the middle of a pulse, coin held through release
    bus.JOY1[7] = 1'b1;
    step(FRAME_LEN);
    check("midpulse_on", {7'd0, bus.CTR1[7]}, 8'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_coin", {7'd0, bus.CTR1[7]}, 8'd1);
    step(2);
    rst_n = 1'b1;
    pulses = 0;
    step(6 * FRAME_LEN);
    check_int("held_reset_pulses", pulses, 0);
    bus.JOY1[7] = 1'b0;
    step(3);

    // Random traffic against the model
    repeat (3000) begin
      random_inputs();
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
